signed_shift_result_buf: RTL

// - Downstream stage of the signed shifter: captures {result, overflow} into a 2-entry buffer.
// - Decouples the combinational shifter from the ALU writeback path via valid/ready handshakes.
// - Keeps a sticky overflow status bit and a saturating overflow event counter for the ALU status logic.

---
 rtl/signed_shift_result_buf.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/signed_shift_result_buf.sv
// signed_shift_result_buf: two-entry result buffer behind the signed shifter.
// Holds {result, overflow} entries with valid/ready on both sides, and keeps
// a sticky overflow flag and a saturating overflow event counter.
// Optional build macro SIGNED_SHIFT_SAT_EN: overflowing results are stored
// as the signed min/max value selected by in_sign.
module signed_shift_result_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_of,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_of,
  input  logic              ovf_clr,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // FIFO storage and control
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        of_mem_q, of_mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Registered outputs
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_of_q, out_of_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] store_data_c;

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Value written into the slot on push
`ifdef SIGNED_SHIFT_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  always_comb begin
    store_data_c = in_data;
    if (in_of) begin
      store_data_c = in_sign ? SAT_MIN : SAT_MAX;
    end
  end
`else
  logic unused_in_sign;
  assign unused_in_sign = in_sign;
  always_comb begin
    store_data_c = in_data;
  end
`endif

  // Next-state: pointers, occupancy, storage, status and output registers
  always_comb begin
    mem_d       = mem_q;
    of_mem_d    = of_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (push_c) begin
      mem_d[wr_ptr_q]    = store_data_c;
      of_mem_d[wr_ptr_q] = in_of;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // Set beats clear on the same cycle
    if (push_c && in_of) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end

    // Clear restarts the count, including the overflow pushed this cycle
    if (ovf_clr) begin
      cnt_d = (push_c && in_of) ? CNT_W'(1) : '0;
    end else if (push_c && in_of && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    in_ready_d  = (occ_d != OCC_FULL);
    out_valid_d = (occ_d != '0);
    out_data_d  = mem_d[rd_ptr_d];
    out_of_d    = of_mem_d[rd_ptr_d];
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      of_mem_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_of_q    <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      of_mem_q    <= of_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_of_q    <= out_of_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_of     = out_of_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule
